// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM states, frame framing constants and
// common keyboard scan codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_I     = 8'h43;
  localparam logic [7:0] KEY_J     = 8'h3B;
  localparam logic [7:0] KEY_K     = 8'h42;
  localparam logic [7:0] KEY_L     = 8'h4B;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings the raw PS/2 clock and data into the clk domain and debounces the
// clock, emitting a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic filt_clk,
  output logic sync_data,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [CW-1:0] cnt;

  // The counter tracks how long the synchronized clock has disagreed with the
  // filtered level; any agreeing sample throws the run away.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        cnt      <= '0;
        fall     <= filt_clk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sync_data = data_sync[1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver keeping a four-byte history of scan codes.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keycode,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          filt_clk;
  logic          sync_data;
  logic          fall;
  logic          bit_event;
  ps2_state_t    state;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity_ok;
  logic [TW-1:0] tcnt;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .filt_clk (filt_clk),
    .sync_data(sync_data),
    .fall     (fall)
  );

  assign bit_event = fall & ~filt_clk;

  // A bit event always takes priority over the inactivity timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      tcnt      <= '0;
      keycode   <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (bit_event && sync_data == START_BIT) begin
          state   <= DATA;
          bit_idx <= '0;
        end
      end else if (bit_event) begin
        tcnt <= '0;
        case (state)
          DATA: begin
            shift   <= {sync_data, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_ok <= odd_parity_ok(shift, sync_data);
`else
            parity_ok <= 1'b1;
`endif
            state <= STOP;
          end
          STOP: begin
            if (sync_data == STOP_BIT && parity_ok) begin
              keycode   <= {keycode[23:0], shift};
              key_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        tcnt      <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: a table of directed frames followed
// by random frames checked against a byte-level model of the keyboard link.
module tb_ps2_keycode_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 25;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        bad_par;
    logic        stop;
    int          glitch_bit;
    logic        exp_accept;
    logic [31:0] exp_kc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keycode;
  logic        key_valid;
  logic        frame_err;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int v0, e0;
  logic [31:0] model_kc;
  vec_t tbl[7];

  ps2_keycode_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [10:0] make_bits(input logic [7:0] d, input logic bad_par, input logic stop);
    logic par;
    par = (~^d) ^ bad_par;
    return {stop, par, d, 1'b0};
  endfunction

  // Drives bits LSB first; data changes while the line clock is high and an
  // optional 3-cycle low glitch is inserted in the high phase of one bit.
  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cycles(5);
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(HALF - 8);
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    wait_cycles(HALF / 2);
    ps2_data = 1'b1;
    wait_cycles(30);
  endtask

  task automatic applyStimulus(input vec_t v);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(make_bits(v.data, v.bad_par, v.stop), 11, v.glitch_bit);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_kc, input int exp_v, input int exp_e);
    check_val({name, "_keycode"}, keycode, exp_kc);
    check_val({name, "_valid_pulses"}, 32'(valid_cnt - v0), 32'(exp_v));
    check_val({name, "_err_pulses"}, 32'(err_cnt - e0), 32'(exp_e));
  endtask

  // Reference: a frame is accepted iff its stop bit is 1 and, when parity
  // checking is built in, its parity is correct; accepted bytes shift in.
  function automatic logic model_accept(input logic bad_par, input logic stop);
    return stop && !(PAR_EN && bad_par);
  endfunction

  initial begin
    tbl[0] = '{8'h1D, 1'b0, 1'b1, -1, 1'b1, 32'h0000001D};
    tbl[1] = '{8'hF0, 1'b0, 1'b1, -1, 1'b1, 32'h00001DF0};
    tbl[2] = '{8'h1D, 1'b0, 1'b1, -1, 1'b1, 32'h001DF01D};
`ifdef PS2_PARITY_CHECK_EN
    tbl[3] = '{8'h23, 1'b1, 1'b1, -1, 1'b0, 32'h001DF01D};
    tbl[4] = '{8'h42, 1'b0, 1'b1,  3, 1'b1, 32'h1DF01D42};
    tbl[5] = '{8'hE0, 1'b0, 1'b0, -1, 1'b0, 32'h1DF01D42};
    tbl[6] = '{8'h4B, 1'b0, 1'b1, -1, 1'b1, 32'hF01D424B};
`else
    tbl[3] = '{8'h23, 1'b1, 1'b1, -1, 1'b1, 32'h1DF01D23};
    tbl[4] = '{8'h42, 1'b0, 1'b1,  3, 1'b1, 32'hF01D2342};
    tbl[5] = '{8'hE0, 1'b0, 1'b0, -1, 1'b0, 32'hF01D2342};
    tbl[6] = '{8'h4B, 1'b0, 1'b1, -1, 1'b1, 32'h1D23424B};
`endif

    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(1);
    check_val("reset_keycode", keycode, 32'h0);
    check_val("reset_key_valid", 32'(key_valid), 32'h0);
    check_val("reset_frame_err", 32'(frame_err), 32'h0);
    model_kc = 32'h0;

    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        // Low glitch in idle with data low must not look like a start bit.
        ps2_data = 1'b0;
        wait_cycles(5);
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(5);
        ps2_data = 1'b1;
        wait_cycles(10);
      end
      if (i == 6) begin
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(make_bits(8'h4B, 1'b0, 1'b1), 6, -1);
        for (int c = 0; c < TIMEOUT_CYC + 200 && err_cnt == e0; c++) wait_cycles(1);
        wait_cycles(20);
        checkOutput("timeout", model_kc, 0, 1);
      end
      applyStimulus(tbl[i]);
      if (model_accept(tbl[i].bad_par, tbl[i].stop)) model_kc = {model_kc[23:0], tbl[i].data};
      check_val($sformatf("vec%0d_model", i), model_kc, tbl[i].exp_kc);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp_kc, int'(tbl[i].exp_accept), int'(!tbl[i].exp_accept));
    end

    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(make_bits(8'h1C, 1'b0, 1'b1), 5, -1);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    model_kc = 32'h0;
    wait_cycles(TIMEOUT_CYC + 50);
    checkOutput("mid_reset", 32'h0, 0, 0);
    applyStimulus('{8'h1C, 1'b0, 1'b1, -1, 1'b1, 32'h0000001C});
    model_kc = {model_kc[23:0], 8'h1C};
    checkOutput("after_reset", 32'h0000001C, 1, 0);

    for (int r = 0; r < 16; r++) begin
      vec_t v;
      logic acc;
      v.data       = 8'($urandom_range(0, 255));
      v.bad_par    = ($urandom_range(0, 3) == 0);
      v.stop       = ($urandom_range(0, 7) != 0);
      v.glitch_bit = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      acc = model_accept(v.bad_par, v.stop);
      if (acc) model_kc = {model_kc[23:0], v.data};
      v.exp_accept = acc;
      v.exp_kc     = model_kc;
      applyStimulus(v);
      checkOutput($sformatf("rand%0d", r), v.exp_kc, int'(acc), int'(!acc));
    end

    check_val("no_overlap", 32'(both_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
